// File: rtl/cplx_mult_arbiter_if.sv
// -----------------------------------------------------------------------------
// cplx_mult_arbiter_if
// Bundles every handshake and bus signal of cplx_mult_arbiter. This includes
// both requester ports and the port toward the external complex multiplier.
//
// Parameters
//   DATA_WIDTH : width of one real/imaginary operand component
//   OP_W       : packed operand width {a_re, a_im, b_re, b_im}
//   RES_W      : packed result width {res_re, res_im}
//
// Modports
//   slave  : arbiter view. Requester operands come in and results go out;
//            operands go out to the multiplier and results come back.
//   master : surrounding-system view (requesters plus multiplier), the mirror
//            image of slave.
// -----------------------------------------------------------------------------
interface cplx_mult_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_W       = 4*DATA_WIDTH,
  parameter int RES_W      = 4*DATA_WIDTH+2
);
  // Requester 0
  logic             req0_op_val;
  logic [OP_W-1:0]  req0_op;
  logic             req0_op_ready;
  logic             req0_res_val;
  logic             req0_res_ready;
  // Requester 1
  logic             req1_op_val;
  logic [OP_W-1:0]  req1_op;
  logic             req1_op_ready;
  logic             req1_res_val;
  logic             req1_res_ready;
  // Shared result bus, qualified by reqN_res_val
  logic [RES_W-1:0] req_res;
  // Multiplier side
  logic             m_op_val;
  logic [OP_W-1:0]  m_op;
  logic             m_op_ready;
  logic             m_res_val;
  logic [RES_W-1:0] m_res;
  logic             m_res_ready;

  modport slave (
    input  req0_op_val, req0_op, req0_res_ready,
    input  req1_op_val, req1_op, req1_res_ready,
    input  m_op_ready, m_res_val, m_res,
    output req0_op_ready, req0_res_val,
    output req1_op_ready, req1_res_val,
    output req_res, m_op_val, m_op, m_res_ready
  );

  modport master (
    output req0_op_val, req0_op, req0_res_ready,
    output req1_op_val, req1_op, req1_res_ready,
    output m_op_ready, m_res_val, m_res,
    input  req0_op_ready, req0_res_val,
    input  req1_op_ready, req1_res_val,
    input  req_res, m_op_val, m_op, m_res_ready
  );
endinterface

// File: rtl/cplx_mult_arbiter.sv
// -----------------------------------------------------------------------------
// cplx_mult_arbiter
// Shares one external complex multiplier between two requesters. Only one
// transaction is in flight at a time:
//   IDLE -> ISSUE -> WAIT_RES -> RETURN -> IDLE
// The steps are: accept an operand, hand it to the multiplier, capture the
// product, then return the product to whichever requester was granted.
//
// Ports
//   clk    : single clock, rising edge
//   rstn   : asynchronous active-low reset
//   sw_rst : synchronous active-high software reset. It discards any
//            in-flight transaction.
//   bus    : cplx_mult_arbiter_if.slave. Carries the requester
//            operand/result handshakes, the shared req_res bus, and the
//            multiplier handshakes.
//
// Configuration
//   CPLX_ARB_RR_EN : when defined, a round-robin choice between two
//                    simultaneous requesters, using last_grant. When
//                    undefined, requester 0 has fixed priority.
// -----------------------------------------------------------------------------
module cplx_mult_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_W       = 4*DATA_WIDTH,
  parameter int RES_W      = 4*DATA_WIDTH+2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sw_rst,
  cplx_mult_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ISSUE    = 2'b01,
    WAIT_RES = 2'b10,
    RETURN   = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             grant;
  logic [OP_W-1:0]  op_reg;
  logic [RES_W-1:0] res_reg;
  logic             sel;
  logic             any_val;
  logic             accept;
  logic             load_res;

  assign any_val = bus.req0_op_val | bus.req1_op_val;

`ifdef CPLX_ARB_RR_EN
  logic last_grant;
  logic release_res;

  // Arbitration between the two requesters.
  // With both requesters valid, pick the one that was not served last.
  // With only one valid, pick that one. With neither valid, sel is unused.
  always_comb begin
    sel = 1'b0;
    if (bus.req0_op_val && bus.req1_op_val) begin
      sel = ~last_grant;
    end else if (bus.req1_op_val) begin
      sel = 1'b1;
    end
  end

  // The result is delivered when the granted requester takes it.
  assign release_res = (state == RETURN) &&
                       (grant ? bus.req1_res_ready : bus.req0_res_ready);

  // History used by the round-robin choice.
  // Its reset value of 1 means requester 0 wins the first contest.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= 1'b1;
    end else if (sw_rst) begin
      last_grant <= 1'b1;
    end else if (release_res) begin
      last_grant <= grant;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it is valid.
  // Otherwise requester 1 is picked; that choice only matters if
  // requester 1 is valid.
  assign sel = ~bus.req0_op_val;
`endif

  // State register.
  // Software reset takes precedence over every transition.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else if (sw_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and handshake outputs.
  // Ready/valid signals depend only on the state, the requester op_val
  // inputs and grant. As a result there is no path from m_op_ready to
  // reqN_op_ready, and no path from reqN_res_ready to m_op_val.
  always_comb begin
    state_nxt         = state;
    accept            = 1'b0;
    load_res          = 1'b0;
    bus.req0_op_ready = 1'b0;
    bus.req1_op_ready = 1'b0;
    bus.req0_res_val  = 1'b0;
    bus.req1_res_val  = 1'b0;
    bus.m_op_val      = 1'b0;
    bus.m_res_ready   = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_op_ready = any_val & ~sel;
        bus.req1_op_ready = any_val & sel;
        if (any_val) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.m_op_val = 1'b1;
        if (bus.m_op_ready) begin
          state_nxt = WAIT_RES;
        end
      end
      WAIT_RES: begin
        bus.m_res_ready = 1'b1;
        if (bus.m_res_val) begin
          load_res  = 1'b1;
          state_nxt = RETURN;
        end
      end
      RETURN: begin
        bus.req0_res_val = ~grant;
        bus.req1_res_val = grant;
        if (grant ? bus.req1_res_ready : bus.req0_res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction registers: the operand, the grant, and the product.
  // Each is loaded only on its own handshake, so values presented outside
  // the matching state are ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant   <= 1'b0;
      op_reg  <= '0;
      res_reg <= '0;
    end else if (sw_rst) begin
      grant   <= 1'b0;
      op_reg  <= '0;
      res_reg <= '0;
    end else begin
      if (accept) begin
        grant  <= sel;
        op_reg <= sel ? bus.req1_op : bus.req0_op;
      end
      if (load_res) begin
        res_reg <= bus.m_res;
      end
    end
  end

  assign bus.m_op    = op_reg;
  assign bus.req_res = res_reg;

endmodule

// File: tb/tb_cplx_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cplx_mult_arbiter
// Scoreboard bench for cplx_mult_arbiter.
//
// - Requester inputs are driven from the main initial block.
// - A behavioural multiplier computes the complex product of what it
//   receives, after a random or fixed latency.
// - A tracker pushes the expected product onto a queue whenever an operand is
//   accepted. The tracker also checks arbitration against the rule:
//     fixed priority by default, or round-robin under CPLX_ARB_RR_EN.
// - A monitor pops the queue and compares whenever a result is handed over.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cplx_mult_arbiter;
  localparam int DW    = 8;
  localparam int OP_W  = 4*DW;
  localparam int RES_W = 4*DW+2;
  localparam int CW    = 2*DW+1;
`ifdef CPLX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic             id;
    logic [OP_W-1:0]  op;
    logic [RES_W-1:0] res;
  } txn_t;

  logic clk;
  logic rstn;
  logic sw_rst;
  int   errors = 0;
  int   checks = 0;

  txn_t exp_q[$];
  int   grant_log[$];
  bit   busy;
  bit   cur_id;
  bit   last_id;

  bit               mul_pending;
  int               mul_cnt;
  logic [RES_W-1:0] mul_res;
  int               lat_fixed    = -1;
  bit               mop_hold_low = 1'b0;

  cplx_mult_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  cplx_mult_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .sw_rst (sw_rst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference arithmetic: (a_re + j a_im) * (b_re + j b_im).
  function automatic logic [RES_W-1:0] cmul(input logic [OP_W-1:0] op);
    int ar, ai, br, bi, re, im;
    logic [CW-1:0] re_w, im_w;
    ar   = int'($signed(op[4*DW-1 -: DW]));
    ai   = int'($signed(op[3*DW-1 -: DW]));
    br   = int'($signed(op[2*DW-1 -: DW]));
    bi   = int'($signed(op[DW-1 -: DW]));
    re   = ar*br - ai*bi;
    im   = ar*bi + ai*br;
    re_w = re[CW-1:0];
    im_w = im[CW-1:0];
    return {re_w, im_w};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  // Behavioural multiplier: latches an operand on its handshake, then
  // presents the product after the programmed latency. While idle it emits
  // junk results, which the arbiter must ignore.
  always @(negedge clk) begin
    if (rstn) checkOutput("m_res_ready", 64'(bus.m_res_ready), 64'(mul_pending));
    if (!rstn || sw_rst) begin
      mul_pending = 1'b0;
    end else if (!mul_pending && bus.m_op_val && bus.m_op_ready) begin
      mul_pending = 1'b1;
      mul_res     = cmul(bus.m_op);
      mul_cnt     = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
    end else if (mul_pending && bus.m_res_val && bus.m_res_ready) begin
      mul_pending = 1'b0;
    end
  end

  initial begin
    bus.m_op_ready = 1'b0;
    bus.m_res_val  = 1'b0;
    bus.m_res      = '0;
    forever begin
      tick();
      if (mul_pending) begin
        if (mul_cnt == 0) begin
          bus.m_res_val = 1'b1;
          bus.m_res     = mul_res;
        end else begin
          mul_cnt--;
          bus.m_res_val = 1'b0;
        end
      end else begin
        bus.m_res_val = ($urandom_range(0, 3) == 0);
        bus.m_res     = RES_W'({$urandom, $urandom});
      end
      bus.m_op_ready = mop_hold_low ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Tracker: arbitration model plus scoreboard push on each accepted operand.
  always @(negedge clk) begin
    bit v0, v1, pick;
    if (!rstn) begin
      busy    = 1'b0;
      last_id = 1'b1;
      exp_q.delete();
    end else begin
      v0 = bus.req0_op_val;
      v1 = bus.req1_op_val;
      if (!busy) begin
        if (v0 && v1) pick = RR ? !last_id : 1'b0;
        else          pick = v1;
        checkOutput("op_ready0", 64'(bus.req0_op_ready), 64'((v0 || v1) && !pick));
        checkOutput("op_ready1", 64'(bus.req1_op_ready), 64'((v0 || v1) && pick));
        checkOutput("idle_m_op_val", 64'(bus.m_op_val), 64'(0));
        checkOutput("idle_res_val", 64'({bus.req1_res_val, bus.req0_res_val}), 64'(0));
        if (!sw_rst && ((v0 && bus.req0_op_ready) || (v1 && bus.req1_op_ready))) begin
          txn_t t;
          t.id  = v1 && bus.req1_op_ready;
          t.op  = t.id ? bus.req1_op : bus.req0_op;
          t.res = cmul(t.op);
          exp_q.push_back(t);
          grant_log.push_back(int'(t.id));
          busy   = 1'b1;
          cur_id = t.id;
        end
      end else begin
        checkOutput("busy_op_ready", 64'({bus.req1_op_ready, bus.req0_op_ready}), 64'(0));
        checkOutput("other_res_val", 64'(cur_id ? bus.req0_res_val : bus.req1_res_val), 64'(0));
        if (!sw_rst && (cur_id ? (bus.req1_res_val && bus.req1_res_ready)
                               : (bus.req0_res_val && bus.req0_res_ready))) begin
          busy    = 1'b0;
          last_id = cur_id;
        end
      end
      if (sw_rst) begin
        busy    = 1'b0;
        last_id = 1'b1;
        exp_q.delete();
      end
    end
  end

  // Monitor: pops the scoreboard on result handovers and checks that stalled
  // outputs stay put.
  bit               prev_mop_stall;
  logic [OP_W-1:0]  prev_mop;
  bit               prev_res_stall;
  bit               prev_res_id;
  logic [RES_W-1:0] prev_res;
  txn_t             got;

  always @(negedge clk) begin
    if (!rstn || sw_rst) begin
      prev_mop_stall = 1'b0;
      prev_res_stall = 1'b0;
    end else begin
      if (prev_mop_stall) begin
        checkOutput("m_op_val_hold", 64'(bus.m_op_val), 64'(1));
        checkOutput("m_op_hold", 64'(bus.m_op), 64'(prev_mop));
      end
      if (bus.m_op_val && bus.m_op_ready) begin
        if (exp_q.size() == 0) note_fail("unexpected_m_op");
        else checkOutput("m_op", 64'(bus.m_op), 64'(exp_q[0].op));
      end
      prev_mop_stall = bus.m_op_val && !bus.m_op_ready;
      prev_mop       = bus.m_op;

      if (prev_res_stall) begin
        checkOutput("res_val_hold", 64'(prev_res_id ? bus.req1_res_val : bus.req0_res_val), 64'(1));
        checkOutput("req_res_hold", 64'(bus.req_res), 64'(prev_res));
      end
      if ((bus.req0_res_val && bus.req0_res_ready) || (bus.req1_res_val && bus.req1_res_ready)) begin
        if (exp_q.size() == 0) begin
          note_fail("unexpected_result");
        end else begin
          got = exp_q.pop_front();
          checkOutput("res_id", 64'(bus.req1_res_val), 64'(got.id));
          checkOutput("req_res", 64'(bus.req_res), 64'(got.res));
        end
      end
      prev_res_stall = (bus.req0_res_val && !bus.req0_res_ready) ||
                       (bus.req1_res_val && !bus.req1_res_ready);
      prev_res_id    = bus.req1_res_val;
      prev_res       = bus.req_res;
    end
  end

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.req0_op_val    = 1'($urandom_range(0, 1));
      bus.req1_op_val    = 1'($urandom_range(0, 1));
      bus.req0_op        = $urandom;
      bus.req1_op        = $urandom;
      bus.req0_res_ready = 1'($urandom_range(0, 1));
      bus.req1_res_ready = 1'($urandom_range(0, 1));
      sw_rst             = ($urandom_range(0, 63) == 0);
    end
  endtask

  task automatic drain(input string name);
    tick();
    bus.req0_op_val    = 1'b0;
    bus.req1_op_val    = 1'b0;
    bus.req0_res_ready = 1'b1;
    bus.req1_res_ready = 1'b1;
    sw_rst             = 1'b0;
    for (int i = 0; i < 100 && busy; i++) settle();
    if (busy) note_fail(name);
  endtask

  task automatic wait_res(input bit id, input string name, output bit ok);
    for (int i = 0; i < 40 && !(id ? bus.req1_res_val : bus.req0_res_val); i++) settle();
    ok = id ? bus.req1_res_val : bus.req0_res_val;
    if (!ok) note_fail(name);
  endtask

  logic [OP_W-1:0]  op_x;
  logic [RES_W-1:0] exp_res;
  int               exp_g[4];
  bit               ok;

  initial begin
    rstn               = 1'b0;
    sw_rst             = 1'b0;
    bus.req0_op_val    = 1'b0;
    bus.req1_op_val    = 1'b0;
    bus.req0_op        = '0;
    bus.req1_op        = '0;
    bus.req0_res_ready = 1'b0;
    bus.req1_res_ready = 1'b0;

    // Reset values, including the live IDLE arbitration.
    settle();
    checkOutput("rst_m_op_val", 64'(bus.m_op_val), 64'(0));
    checkOutput("rst_m_res_ready", 64'(bus.m_res_ready), 64'(0));
    checkOutput("rst_res_val", 64'({bus.req1_res_val, bus.req0_res_val}), 64'(0));
    checkOutput("rst_op_ready", 64'({bus.req1_op_ready, bus.req0_op_ready}), 64'(0));
    checkOutput("rst_m_op", 64'(bus.m_op), 64'(0));
    checkOutput("rst_req_res", 64'(bus.req_res), 64'(0));
    bus.req1_op_val = 1'b1;
    #1;
    checkOutput("rst_arb_req1", 64'({bus.req1_op_ready, bus.req0_op_ready}), 64'(2));
    bus.req0_op_val = 1'b1;
    #1;
    checkOutput("rst_arb_both", 64'({bus.req1_op_ready, bus.req0_op_ready}), 64'(1));
    tick();
    bus.req0_op_val = 1'b0;
    bus.req1_op_val = 1'b0;
    rstn            = 1'b1;

    // Single req0 transaction with a known product: (1+2j)(3+4j) = -5+10j.
    tick();
    bus.req0_op_val    = 1'b1;
    bus.req0_op        = 32'h01020304;
    bus.req0_res_ready = 1'b1;
    settle();
    checkOutput("t1_op_ready", 64'(bus.req0_op_ready), 64'(1));
    tick();
    bus.req0_op_val = 1'b0;
    settle();
    checkOutput("t1_m_op_val", 64'(bus.m_op_val), 64'(1));
    checkOutput("t1_m_op", 64'(bus.m_op), 64'(32'h01020304));
    wait_res(1'b0, "t1_res_val", ok);
    exp_res = {17'h1FFFB, 17'h0000A};
    if (ok) checkOutput("t1_req_res", 64'(bus.req_res), 64'(exp_res));
    drain("t1_drain");

    // Both requesters continuously valid, starting from a fresh reset.
    tick();
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    grant_log.delete();
    bus.req0_op_val = 1'b1;
    bus.req1_op_val = 1'b1;
    for (int i = 0; i < 200 && grant_log.size() < 4; i++) begin
      tick();
      bus.req0_op = $urandom;
      bus.req1_op = $urandom;
    end
    drain("t2_drain");
    if (RR) exp_g = '{0, 1, 0, 1};
    else    exp_g = '{0, 0, 0, 0};
    if (grant_log.size() < 4) begin
      note_fail("t2_grant_count");
    end else begin
      for (int i = 0; i < 4; i++) checkOutput($sformatf("t2_grant%0d", i), 64'(grant_log[i]), 64'(exp_g[i]));
    end

    // Multiplier stalls operand acceptance for 5 cycles.
    mop_hold_low = 1'b1;
    op_x         = $urandom;
    tick();
    bus.req0_op_val = 1'b1;
    bus.req0_op     = op_x;
    tick();
    bus.req1_op_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      checkOutput("t3_m_op_val", 64'(bus.m_op_val), 64'(1));
      checkOutput("t3_m_op", 64'(bus.m_op), 64'(op_x));
      checkOutput("t3_op_ready", 64'({bus.req1_op_ready, bus.req0_op_ready}), 64'(0));
    end
    tick();
    mop_hold_low    = 1'b0;
    bus.req0_op_val = 1'b0;
    bus.req1_op_val = 1'b0;
    drain("t3_drain");

    // Requester 1 holds off its result for 3 cycles: (-3+7j)(5-2j) = -1+41j.
    op_x = {8'hFD, 8'h07, 8'h05, 8'hFE};
    exp_res = {17'h1FFFF, 17'd41};
    tick();
    bus.req1_op_val    = 1'b1;
    bus.req1_op        = op_x;
    bus.req1_res_ready = 1'b0;
    tick();
    bus.req1_op_val = 1'b0;
    wait_res(1'b1, "t4_res_val", ok);
    for (int i = 0; i < 3 && ok; i++) begin
      checkOutput("t4_res_val1", 64'(bus.req1_res_val), 64'(1));
      checkOutput("t4_req_res", 64'(bus.req_res), 64'(exp_res));
      checkOutput("t4_res_val0", 64'(bus.req0_res_val), 64'(0));
      settle();
    end
    drain("t4_drain");

    // Software reset while waiting on the multiplier, then a clean req1 job.
    lat_fixed = 6;
    tick();
    bus.req0_op_val = 1'b1;
    bus.req0_op     = $urandom;
    tick();
    bus.req0_op_val = 1'b0;
    for (int i = 0; i < 30 && !mul_pending; i++) settle();
    if (!mul_pending) note_fail("t5_wait_res");
    tick();
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    settle();
    checkOutput("t5_res_val", 64'({bus.req1_res_val, bus.req0_res_val}), 64'(0));
    checkOutput("t5_m_res_ready", 64'(bus.m_res_ready), 64'(0));
    checkOutput("t5_m_op_val", 64'(bus.m_op_val), 64'(0));
    lat_fixed = -1;
    op_x      = $urandom;
    exp_res   = cmul(op_x);
    tick();
    bus.req1_op_val = 1'b1;
    bus.req1_op     = op_x;
    tick();
    bus.req1_op_val = 1'b0;
    wait_res(1'b1, "t5_res_val1", ok);
    if (ok) checkOutput("t5_req_res", 64'(bus.req_res), 64'(exp_res));
    drain("t5_drain");

    // Randomised traffic with occasional software resets.
    applyStimulus(1500);
    drain("rand_drain");
    checkOutput("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
